// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// Executes the eight classic logic/arithmetic ops in one cycle, bit-serial shifts
// (one bit per cycle) and a WIDTH-cycle shift-add multiply. One operation in flight.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready high only while idle)
//   A, B, S             operands and opcode, latched on the accept edge
//   out_valid/out_ready result handshake (result held while out_ready is low)
//   Y                   result
//   C, V, Z, N, ERR     carry, signed overflow, zero, negative, illegal opcode
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             ERR
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned M  = WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q;
    logic [3:0]         s_q;
    logic [CW:0]        cnt_q;
    logic [WIDTH-1:0]   work_q;     // shift operand
    logic [WIDTH-1:0]   mr_q;       // multiplier, consumed LSB first
    logic [2*WIDTH-1:0] md_q;       // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] acc_q;      // partial product
    logic [WIDTH-1:0]   y_q;
    logic               c_q, v_q, z_q, n_q, err_q;

    // Single-cycle result for the operation presented at the inputs.
    logic [WIDTH-1:0]   y_d;
    logic               c_d, v_d, err_d;
    logic [WIDTH:0]     sum;
    logic [CW:0]        cnt_in;

    assign cnt_in = {1'b0, B[CW-1:0]};

    always_comb begin
        y_d   = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        err_d = 1'b0;
        sum   = '0;
        case (S)
            4'd0: y_d = ~A;
            4'd1: y_d = A | B;
            4'd2: y_d = A & B;
            4'd3: y_d = A ^ B;
            4'd4: begin
                sum = {1'b0, A} + {1'b0, B};
                y_d = sum[WIDTH-1:0];
                c_d = sum[WIDTH];
                v_d = (A[M] == B[M]) && (y_d[M] != A[M]);
            end
            4'd5: begin
                sum = {1'b0, A} + (WIDTH+1)'(1);
                y_d = sum[WIDTH-1:0];
                c_d = sum[WIDTH];
                v_d = ~A[M] & y_d[M];
            end
            4'd6: begin
                sum = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                y_d = sum[WIDTH-1:0];
                c_d = sum[WIDTH];
                v_d = (A[M] != B[M]) && (y_d[M] != A[M]);
            end
            4'd7: begin
                y_d = A - WIDTH'(1);
                c_d = |A;
                v_d = A[M] & ~y_d[M];
            end
            // Zero-count shifts complete here; nonzero counts and MUL finish in EXEC.
            4'd8, 4'd9: y_d = A;
            4'd10:      y_d = '0;
            default:    err_d = 1'b1;
        endcase
    end

    // One EXEC step and the result it yields if it is the last one.
    logic [WIDTH-1:0]   shl, shr, fin_y;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               fin_c;

    always_comb begin
        shl     = {work_q[WIDTH-2:0], 1'b0};
        shr     = {1'b0, work_q[WIDTH-1:1]};
        acc_nxt = acc_q + (mr_q[0] ? md_q : '0);
        if (s_q == 4'd10) begin
            fin_y = acc_nxt[WIDTH-1:0];
            fin_c = |acc_nxt[2*WIDTH-1:WIDTH];
        end else if (s_q == 4'd8) begin
            fin_y = shl;
            fin_c = work_q[WIDTH-1];
        end else begin
            fin_y = shr;
            fin_c = work_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            mr_q    <= '0;
            md_q    <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        s_q    <= S;
                        work_q <= A;
                        mr_q   <= B;
                        md_q   <= {{WIDTH{1'b0}}, A};
                        acc_q  <= '0;
                        if ((S == 4'd8 || S == 4'd9) && cnt_in != '0) begin
                            cnt_q   <= cnt_in;
                            state_q <= StExec;
                        end else if (S == 4'd10) begin
                            cnt_q   <= (CW+1)'(WIDTH);
                            state_q <= StExec;
                        end else begin
                            y_q     <= y_d;
                            c_q     <= c_d;
                            v_q     <= v_d;
                            z_q     <= (y_d == '0);
                            n_q     <= y_d[M];
                            err_q   <= err_d;
                            state_q <= StDone;
                        end
                    end
                end
                StExec: begin
                    work_q <= (s_q == 4'd8) ? shl : shr;
                    acc_q  <= acc_nxt;
                    md_q   <= md_q << 1;
                    mr_q   <= mr_q >> 1;
                    cnt_q  <= cnt_q - (CW+1)'(1);
                    // Only the final step updates the visible result.
                    if (cnt_q == (CW+1)'(1)) begin
                        y_q     <= fin_y;
                        c_q     <= fin_c;
                        v_q     <= 1'b0;
                        z_q     <= (fin_y == '0);
                        n_q     <= fin_y[M];
                        err_q   <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Y         = y_q;
    assign C         = c_q;
    assign V         = v_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign ERR       = err_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the 4-bit combinational ALU. It takes operands through a valid/ready input handshake, executes the eight original logic/arithmetic operations in one cycle and adds multi-cycle shift and multiply operations. It returns a registered result with status flags through a valid/ready output handshake. It sits between a register file or sequencer and a result writeback stage, and processes one operation at a time.

## Interface
- WIDTH, 8: operand/result width in bits; must be at least 2 and a power of two.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for shifts, B[$clog2(WIDTH)-1:0] is the shift count.
- S  input  4  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- Y  output  WIDTH  result.
- C, V, Z, N, ERR  output  1 each  carry, signed overflow, zero, negative, illegal-opcode.

## Operation
- Opcodes:
  - 0: NOT A
  - 1: A|B
  - 2: A&B
  - 3: A^B
  - 4: A+B
  - 5: A+1
  - 6: A-B
  - 7: A-1
  - 8: SHL A by count
  - 9: logical SHR A by count
  - 10: MUL, low WIDTH bits of A*B
  - 11-15: reserved
- FSM states: IDLE, EXEC, DONE.
- in_ready is 1 only in IDLE.
- A transfer occurs when in_valid and in_ready are both high. A, B and S are latched on that edge, and later input changes have no effect.
- Opcodes 0-7, reserved opcodes, and shifts with count 0 go IDLE→DONE at the accept edge, with result and flags registered on that edge.
- Shifts with count n>0 go IDLE→EXEC and shift one bit per cycle for n cycles, then go to DONE.
- MUL goes IDLE→EXEC and runs shift-add for WIDTH cycles, then goes to DONE.
- DONE holds Y and the flags stable while out_ready is low. When out_valid and out_ready are both high, the FSM goes to IDLE. A new operation is not accepted in that same cycle.
- Arithmetic is modulo 2^WIDTH.
- C, by opcode:
  - Logic ops: C=0.
  - ADD/INC: C = carry out.
  - SUB: C = carry out of A+~B+1, so 1 means no borrow.
  - DEC: C = (A≠0).
  - SHL/SHR: C = last bit shifted out; 0 when count is 0.
  - MUL: C = 1 if the upper WIDTH bits of the full product are nonzero.
- V = signed two's-complement overflow for opcodes 4-7; otherwise V=0.
- Z = (Y==0) and N = Y[WIDTH-1], for all legal opcodes.
- Reserved opcode: Y=0, ERR=1, Z=1, C=V=N=0. ERR=0 for every legal opcode.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state goes to IDLE;
  - Y=0, C=V=Z=N=ERR=0, out_valid=0;
  - in_ready=1 from the first cycle after release.
- Reset asserted during EXEC or DONE aborts the operation immediately; no result is produced.
- Latency, from accept edge k:
  - single-cycle ops: out_valid=1 after edge k;
  - shift with count n: out_valid=1 after edge k+n;
  - MUL: out_valid=1 after edge k+WIDTH.
- Throughput: at most one operation per (latency + 1) cycles.
- Handshake rules:
  - in_valid may be high while in_ready is low; that operation waits.
  - out_valid never drops without an accepting out_ready.
- Y and the flags change only on the accept edge, on the final EXEC edge, or at reset. Intermediate EXEC values are never visible on Y.

## Test plan
- WIDTH=4, A=6, B=13, out_ready=1:
  - S=0 → Y=9, N=1.
  - S=1 → Y=15, N=1.
  - S=2 → Y=4.
  - S=3 → Y=11.
  - Each op: out_valid exactly one cycle after accept.
- WIDTH=4, A=9, B=3:
  - S=4 → Y=12, C=0, V=0, N=1.
  - S=6 → Y=6, C=1.
  - S=5 → Y=10, V=0.
- WIDTH=4, boundary cases:
  - A=0, S=7 → Y=15, C=0, N=1.
  - A=7, S=5 → Y=8, V=1.
  - A=15, S=5 → Y=0, C=1, Z=1.
- WIDTH=4, A=6, B=13:
  - S=10 → Y=14, C=1, out_valid 4 cycles after accept.
  - S=8, B=3 → Y=0, C=1, Z=1, out_valid 3 cycles after accept.
  - S=9, B=0 → Y=6, C=0, out_valid 1 cycle after accept.
- Backpressure:
  - hold out_ready=0 for 3 cycles in DONE → Y and flags stable, in_ready=0;
  - in_valid pulsed high and changed operands ignored;
  - accept on cycle 4 → in_ready=1 next cycle.
- Reset: assert rst_n=0 mid-MUL (cycle 2 of EXEC) → all outputs 0 immediately; after release, S=12 → Y=0, ERR=1, Z=1.
